// File: rtl/bcd_counter_multi.sv
// Multi-digit synchronous BCD counter: up/down, enable, validated parallel load,
// wrap or saturate at the limits, registered terminal-count pulse.
module bcd_counter_multi #(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                tc_q, tc_d;
    logic                err_q, err_d;
    logic                at_term;
    logic                carry;
    logic [3:0]          nib;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        err_d   = err_q;
        at_term = 1'b1;
        carry   = 1'b1;
        nib     = 4'd0;

        for (int unsigned i = 0; i < DIGITS; i++) begin
            nib = count_q[4*i +: 4];
            if (up ? (nib != 4'd9) : (nib != 4'd0)) begin
                at_term = 1'b0;
            end
        end

        if (load) begin
            err_d = 1'b0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                nib = load_val[4*i +: 4];
                if (nib > 4'd9) begin
                    count_d[4*i +: 4] = 4'd0;
                    err_d             = 1'b1;
                end else begin
                    count_d[4*i +: 4] = nib;
                end
            end
        end else if (en) begin
            if (at_term) begin
                // Saturating mode holds the value but still flags each attempted step.
                tc_d = 1'b1;
                if (WRAP) begin
                    for (int unsigned i = 0; i < DIGITS; i++) begin
                        count_d[4*i +: 4] = up ? 4'd0 : 4'd9;
                    end
                end
            end else begin
                // Ripple: a digit steps only while every lower digit sat at its limit.
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    nib = count_q[4*i +: 4];
                    if (carry) begin
                        if (up) begin
                            count_d[4*i +: 4] = (nib == 4'd9) ? 4'd0 : nib + 4'd1;
                        end else begin
                            count_d[4*i +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
                        end
                    end
                    carry = carry & (up ? (nib == 4'd9) : (nib == 4'd0));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
        end
    end

    assign q        = count_q;
    assign tc       = tc_q;
    assign load_err = err_q;

endmodule
